// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package rf_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // One pending register write: destination and value.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Result buffer for the multi-cycle unit. Exposes occupancy, read pointer,
// head entry and the raw storage so the owner can search pending writes.
// The owner never pushes when full nor pops when empty.
module rf_wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  wb_entry_t             pushEntry,
   input  logic                  pop,
   output logic [CNT_W-1:0]      count,
   output logic [PTR_W-1:0]      rdPtr,
   output wb_entry_t             head,
   output wb_entry_t [DEPTH-1:0] entries
);

   wb_entry_t [DEPTH-1:0] mem;
   logic [PTR_W-1:0]      wrPtr;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage write; slots outside [rdPtr, rdPtr+count) are don't-care, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= pushEntry;
   end

   assign head    = mem[rdPtr];
   assign entries = mem;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: merges the core's single-cycle writeback
// with buffered multi-cycle results into one RF write per cycle, flags pending
// destinations to decode, and stalls the core for one cycle when a buffered
// result has waited too long.
// Build option: define RF_WB_FORWARD_EN to drive RsFwd/RtFwd and the forward
// data from the youngest matching buffered entry; otherwise they are tied 0.
//
// Handshakes: a multi-cycle result transfers on a cycle where SecValid and
// SecReady are both high (SecReady reflects the buffer before any pop that
// cycle); results for $0 are acknowledged but dropped. The core's primary
// request has no ready: it is taken on any cycle PriValid is high and Stall is
// low, and the core must hold it unchanged while Stall is high.
module rf_writeback_ctrl
   import rf_wb_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  PriValid,
   input  logic [REG_ADDR_W-1:0] PriAddr,
   input  logic [REG_DATA_W-1:0] PriData,
   input  logic                  SecValid,
   input  logic [REG_ADDR_W-1:0] SecAddr,
   input  logic [REG_DATA_W-1:0] SecData,
   output logic                  SecReady,
   output logic                  Stall,
   input  logic [REG_ADDR_W-1:0] RsAddr,
   input  logic [REG_ADDR_W-1:0] RtAddr,
   output logic                  RsPend,
   output logic                  RtPend,
   output logic                  RsFwd,
   output logic [REG_DATA_W-1:0] RsFwdData,
   output logic                  RtFwd,
   output logic [REG_DATA_W-1:0] RtFwdData,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] RdAddr,
   output logic [REG_DATA_W-1:0] RdData
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [STV_W-1:0] STARVE_LAST = STV_W'(STARVE_MAX - 1);

   logic [CNT_W-1:0]      fifoCount;
   logic [PTR_W-1:0]      fifoRdPtr;
   wb_entry_t             fifoHead;
   wb_entry_t [DEPTH-1:0] fifoEntries;
   logic                  fifoEmpty, fifoFull;
   logic                  issuePri, popSec, pushSec, stallSet;
   logic [STV_W-1:0]      starveCnt;
   logic                  rsHit, rtHit;
   logic [REG_DATA_W-1:0] rsMatch, rtMatch;

   assign fifoEmpty = (fifoCount == '0);
   assign fifoFull  = (fifoCount == CNT_W'(DEPTH));
   assign SecReady  = !fifoFull;

   // Primary wins whenever it is not being stalled; otherwise drain the buffer head.
   assign issuePri = PriValid && !Stall;
   assign popSec   = !issuePri && !fifoEmpty;
   assign pushSec  = SecValid && SecReady && (SecAddr != REG_ZERO);
   // Head has gone unserved long enough: stall the core next cycle so the head drains.
   assign stallSet = !fifoEmpty && !popSec && !Stall && (starveCnt == STARVE_LAST);

   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pushSec),
      .pushEntry ('{addr: SecAddr, data: SecData}),
      .pop       (popSec),
      .count     (fifoCount),
      .rdPtr     (fifoRdPtr),
      .head      (fifoHead),
      .entries   (fifoEntries)
   );

   // Starvation counter and the one-cycle stall it triggers.
   always_ff @(posedge clk) begin
      if (rst) begin
         starveCnt <= '0;
         Stall     <= 1'b0;
      end else begin
         Stall <= stallSet;
         if (popSec || fifoEmpty || stallSet) starveCnt <= '0;
         else                                  starveCnt <= starveCnt + STV_W'(1);
      end
   end

   // Registered RF write port; $0 requests are consumed without a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite <= 1'b0;
         RdAddr   <= '0;
         RdData   <= '0;
      end else if (issuePri) begin
         RegWrite <= (PriAddr != REG_ZERO);
         RdAddr   <= PriAddr;
         RdData   <= PriData;
      end else if (popSec) begin
         RegWrite <= (fifoHead.addr != REG_ZERO);
         RdAddr   <= fifoHead.addr;
         RdData   <= fifoHead.data;
      end else begin
         RegWrite <= 1'b0;
      end
   end

   // Search live entries oldest to youngest; the last hit is the youngest match.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx     = '0;
      rsHit   = 1'b0;
      rtHit   = 1'b0;
      rsMatch = '0;
      rtMatch = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = fifoRdPtr + PTR_W'(k);
         if (CNT_W'(k) < fifoCount) begin
            if ((RsAddr != REG_ZERO) && (fifoEntries[idx].addr == RsAddr)) begin
               rsHit   = 1'b1;
               rsMatch = fifoEntries[idx].data;
            end
            if ((RtAddr != REG_ZERO) && (fifoEntries[idx].addr == RtAddr)) begin
               rtHit   = 1'b1;
               rtMatch = fifoEntries[idx].data;
            end
         end
      end
   end

   assign RsPend = rsHit;
   assign RtPend = rtHit;

`ifdef RF_WB_FORWARD_EN
   assign RsFwd     = rsHit;
   assign RsFwdData = rsMatch;
   assign RtFwd     = rtHit;
   assign RtFwdData = rtMatch;
`else
   logic unusedFwd;
   assign unusedFwd = ^{rsMatch, rtMatch};
   assign RsFwd     = 1'b0;
   assign RsFwdData = '0;
   assign RtFwd     = 1'b0;
   assign RtFwdData = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_rf_writeback_ctrl;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;
`ifdef RF_WB_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        PriValid, SecValid;
   logic [4:0]  PriAddr, SecAddr, RsAddr, RtAddr;
   logic [31:0] PriData, SecData;
   logic        SecReady, Stall, RsPend, RtPend, RsFwd, RtFwd, RegWrite;
   logic [31:0] RsFwdData, RtFwdData, RdData;
   logic [4:0]  RdAddr;

   always #5 clk = ~clk;

   rf_writeback_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .PriValid(PriValid), .PriAddr(PriAddr), .PriData(PriData),
      .SecValid(SecValid), .SecAddr(SecAddr), .SecData(SecData),
      .SecReady(SecReady), .Stall(Stall),
      .RsAddr(RsAddr), .RtAddr(RtAddr),
      .RsPend(RsPend), .RtPend(RtPend),
      .RsFwd(RsFwd), .RsFwdData(RsFwdData),
      .RtFwd(RtFwd), .RtFwdData(RtFwdData),
      .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [36:0] mq[$];     // buffered multi-cycle results, oldest first
   logic [36:0] exp_q[$];  // expected RF writes {addr,data}
   int          mWait;     // cycles the current head has gone unserved
   bit          mStall;
   bit          expReady, expStall, expRsPend, expRtPend, expRsFwd, expRtFwd, expWrite;
   logic [31:0] expRsFwdData, expRtFwdData;
   logic        obsReady, obsStall, obsRsPend, obsRtPend, obsRsFwd, obsRtFwd, obsWrite;
   logic [31:0] obsRsFwdData, obsRtFwdData, obsData;
   logic [4:0]  obsAddr;
   int          total = 0;
   int          bad = 0;

   // ---------------- driver tasks ----------------
   task automatic clearInputs();
      PriValid = 1'b0; PriAddr = '0; PriData = '0;
      SecValid = 1'b0; SecAddr = '0; SecData = '0;
      RsAddr = '0; RtAddr = '0;
   endtask

   // Called at a negedge with inputs applied: samples combinational outputs,
   // advances the model by one cycle, samples registered outputs, returns at negedge.
   task automatic step();
      logic [36:0] e;
      logic [31:0] rsD, rtD;
      bit hadAny, ready, issuePri, doPop;
      #1;
      obsReady = SecReady; obsStall = Stall;
      obsRsPend = RsPend; obsRtPend = RtPend;
      obsRsFwd = RsFwd; obsRtFwd = RtFwd;
      obsRsFwdData = RsFwdData; obsRtFwdData = RtFwdData;
      expReady = (mq.size() < DEPTH);
      expStall = mStall;
      expRsPend = 1'b0; expRtPend = 1'b0; rsD = '0; rtD = '0;
      foreach (mq[i]) begin
         if (RsAddr != 0 && mq[i][36:32] == RsAddr) begin expRsPend = 1'b1; rsD = mq[i][31:0]; end
         if (RtAddr != 0 && mq[i][36:32] == RtAddr) begin expRtPend = 1'b1; rtD = mq[i][31:0]; end
      end
      expRsFwd = FWD_ON && expRsPend;
      expRtFwd = FWD_ON && expRtPend;
      expRsFwdData = FWD_ON ? rsD : 32'd0;
      expRtFwdData = FWD_ON ? rtD : 32'd0;
      expWrite = 1'b0;
      if (rst) begin
         mq.delete();
         mWait = 0;
         mStall = 1'b0;
      end else begin
         hadAny   = (mq.size() > 0);
         ready    = (mq.size() < DEPTH);
         issuePri = PriValid && !mStall;
         doPop    = !issuePri && hadAny;
         if (issuePri) begin
            if (PriAddr != 0) begin expWrite = 1'b1; exp_q.push_back({PriAddr, PriData}); end
         end else if (doPop) begin
            e = mq.pop_front();
            expWrite = 1'b1;
            exp_q.push_back(e);
         end
         if (SecValid && ready && SecAddr != 0) mq.push_back({SecAddr, SecData});
         // A head left waiting STARVE_MAX cycles forces exactly one stall cycle.
         if (hadAny && !doPop) mWait++;
         else                  mWait = 0;
         if (mWait == STARVE_MAX) begin
            mStall = !mStall;
            mWait = 0;
         end else begin
            mStall = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      obsWrite = RegWrite; obsAddr = RdAddr; obsData = RdData;
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clearInputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      exp_q.delete();
      #1;
      total++; if (RegWrite !== 1'b0)   begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
      total++; if (RdAddr !== 5'd0)     begin bad++; $display("FAIL reset_rdaddr got=%h exp=0", RdAddr); end
      total++; if (RdData !== 32'd0)    begin bad++; $display("FAIL reset_rddata got=%h exp=0", RdData); end
      total++; if (Stall !== 1'b0)      begin bad++; $display("FAIL reset_stall got=%b exp=0", Stall); end
      total++; if (SecReady !== 1'b1)   begin bad++; $display("FAIL reset_secready got=%b exp=1", SecReady); end
      total++; if (RsPend !== 1'b0)     begin bad++; $display("FAIL reset_rspend got=%b exp=0", RsPend); end
      total++; if (RtPend !== 1'b0)     begin bad++; $display("FAIL reset_rtpend got=%b exp=0", RtPend); end
      total++; if (RsFwd !== 1'b0)      begin bad++; $display("FAIL reset_rsfwd got=%b exp=0", RsFwd); end
      total++; if (RtFwdData !== 32'd0) begin bad++; $display("FAIL reset_rtfwddata got=%h exp=0", RtFwdData); end
      @(negedge clk);
   endtask

   task automatic test_primary();
      clearInputs();
      PriValid = 1'b1; PriAddr = 5'd5; PriData = 32'hDEADBEEF;
      step();
      clearInputs();
      total++; if (obsWrite !== 1'b1)        begin bad++; $display("FAIL pri_regwrite got=%b exp=1", obsWrite); end
      total++; if (obsAddr !== 5'd5)         begin bad++; $display("FAIL pri_rdaddr got=%h exp=05", obsAddr); end
      total++; if (obsData !== 32'hDEADBEEF) begin bad++; $display("FAIL pri_rddata got=%h exp=deadbeef", obsData); end
      step();
      total++; if (obsWrite !== 1'b0)        begin bad++; $display("FAIL pri_idle got=%b exp=0", obsWrite); end
      exp_q.delete();
   endtask

   task automatic test_sec_push();
      clearInputs();
      SecValid = 1'b1; SecAddr = 5'd7; SecData = 32'h11; RsAddr = 5'd7;
      step();
      total++; if (obsReady !== 1'b1)  begin bad++; $display("FAIL sec_ready got=%b exp=1", obsReady); end
      total++; if (obsRsPend !== 1'b0) begin bad++; $display("FAIL sec_pend_before got=%b exp=0", obsRsPend); end
      total++; if (obsWrite !== 1'b0)  begin bad++; $display("FAIL sec_nowrite got=%b exp=0", obsWrite); end
      SecValid = 1'b0;
      step();
      total++; if (obsRsPend !== 1'b1) begin bad++; $display("FAIL sec_pend got=%b exp=1", obsRsPend); end
      total++; if (obsRsFwd !== FWD_ON) begin bad++; $display("FAIL sec_fwd got=%b exp=%b", obsRsFwd, FWD_ON); end
      total++; if (obsRsFwdData !== (FWD_ON ? 32'h11 : 32'h0)) begin bad++; $display("FAIL sec_fwddata got=%h", obsRsFwdData); end
      total++; if (obsWrite !== 1'b1)  begin bad++; $display("FAIL sec_write got=%b exp=1", obsWrite); end
      total++; if (obsAddr !== 5'd7)   begin bad++; $display("FAIL sec_rdaddr got=%h exp=07", obsAddr); end
      total++; if (obsData !== 32'h11) begin bad++; $display("FAIL sec_rddata got=%h exp=11", obsData); end
      step();
      total++; if (obsRsPend !== 1'b0) begin bad++; $display("FAIL sec_pend_after got=%b exp=0", obsRsPend); end
      clearInputs();
      exp_q.delete();
   endtask

   task automatic test_starve();
      int pk = 0;
      int stallSteps = 0;
      int stallAt = -1;
      int ep;
      clearInputs();
      for (int s = 0; s < 14; s++) begin
         PriValid = 1'b1; PriAddr = 5'(pk % 30 + 1); PriData = 32'h1000 + 32'(pk);
         SecValid = (s == 0); SecAddr = 5'd31; SecData = 32'h5EC0;
         step();
         if (obsStall) begin stallSteps++; stallAt = s; end
         total++;
         if (s == STARVE_MAX + 1) begin
            if (obsWrite !== 1'b1 || obsAddr !== 5'd31 || obsData !== 32'h5EC0) begin
               bad++; $display("FAIL starve_secwrite s=%0d got=%b/%h/%h exp=1/1f/5ec0", s, obsWrite, obsAddr, obsData);
            end
         end else begin
            ep = (s <= STARVE_MAX) ? s : s - 1;
            if (obsWrite !== 1'b1 || obsAddr !== 5'(ep % 30 + 1) || obsData !== 32'h1000 + 32'(ep)) begin
               bad++; $display("FAIL starve_priwrite s=%0d got=%b/%h/%h exp=1/%h/%h", s, obsWrite, obsAddr, obsData, 5'(ep % 30 + 1), 32'h1000 + 32'(ep));
            end
         end
         if (!obsStall) pk++;
      end
      total++; if (stallSteps != 1) begin bad++; $display("FAIL starve_count got=%0d exp=1", stallSteps); end
      total++; if (stallAt != STARVE_MAX + 1) begin bad++; $display("FAIL starve_cycle got=%0d exp=%0d", stallAt, STARVE_MAX + 1); end
      clearInputs();
      exp_q.delete();
   endtask

   task automatic test_fifo_full();
      int pk = 0;
      int sk = 0;
      clearInputs();
      for (int s = 0; s < 16; s++) begin
         PriValid = (s <= 10); PriAddr = 5'(pk + 1); PriData = 32'h2000 + 32'(pk);
         SecValid = (sk < 5); SecAddr = 5'(20 + sk); SecData = 32'hA000 + 32'(sk);
         step();
         if (s >= 4 && s <= 8) begin
            total++; if (obsReady !== 1'b0) begin bad++; $display("FAIL full_ready s=%0d got=%b exp=0", s, obsReady); end
         end
         if (s == 9) begin
            total++; if (obsStall !== 1'b1 || obsReady !== 1'b0) begin bad++; $display("FAIL full_popcycle stall=%b ready=%b exp=1/0", obsStall, obsReady); end
            total++; if (obsWrite !== 1'b1 || obsAddr !== 5'd20) begin bad++; $display("FAIL full_firstpop got=%b/%h exp=1/14", obsWrite, obsAddr); end
         end
         if (s == 10) begin
            total++; if (obsReady !== 1'b1) begin bad++; $display("FAIL full_admit got=%b exp=1", obsReady); end
         end
         if (s >= 11 && s <= 14) begin
            total++;
            if (obsWrite !== 1'b1 || obsAddr !== 5'(10 + s) || obsData !== 32'hA000 + 32'(s - 10)) begin
               bad++; $display("FAIL full_drain s=%0d got=%b/%h/%h exp=1/%h/%h", s, obsWrite, obsAddr, obsData, 5'(10 + s), 32'hA000 + 32'(s - 10));
            end
         end
         if (s == 15) begin
            total++; if (obsWrite !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", obsWrite); end
         end
         if (SecValid && obsReady) sk++;
         if (PriValid && !obsStall) pk++;
      end
      clearInputs();
      exp_q.delete();
   endtask

   task automatic test_zero_addr();
      clearInputs();
      for (int s = 0; s < 6; s++) begin
         PriValid = (s < 3); PriAddr = 5'd0; PriData = $urandom;
         SecValid = 1'b1; SecAddr = 5'd0; SecData = $urandom;
         step();
         total++; if (obsWrite !== 1'b0)  begin bad++; $display("FAIL zero_write s=%0d got=%b exp=0", s, obsWrite); end
         total++; if (obsStall !== 1'b0)  begin bad++; $display("FAIL zero_stall s=%0d got=%b exp=0", s, obsStall); end
         total++; if (obsReady !== 1'b1)  begin bad++; $display("FAIL zero_ready s=%0d got=%b exp=1", s, obsReady); end
         total++; if (obsRsPend !== 1'b0 || obsRtPend !== 1'b0) begin bad++; $display("FAIL zero_pend s=%0d got=%b%b exp=00", s, obsRsPend, obsRtPend); end
      end
      clearInputs();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      clearInputs();
      RsAddr = 5'd9;
      for (int s = 0; s < 3; s++) begin
         PriValid = 1'b1; PriAddr = 5'd3; PriData = 32'(s);
         SecValid = 1'b1; SecAddr = 5'(9 + s); SecData = 32'hC000 + 32'(s);
         step();
      end
      total++; if (obsRsPend !== 1'b1) begin bad++; $display("FAIL rstmid_pend_before got=%b exp=1", obsRsPend); end
      rst = 1'b1; SecValid = 1'b0;
      step();
      total++; if (obsWrite !== 1'b0) begin bad++; $display("FAIL rstmid_nowrite got=%b exp=0", obsWrite); end
      rst = 1'b0; PriValid = 1'b0;
      step();
      total++; if (obsReady !== 1'b1)  begin bad++; $display("FAIL rstmid_ready got=%b exp=1", obsReady); end
      total++; if (obsRsPend !== 1'b0) begin bad++; $display("FAIL rstmid_pend got=%b exp=0", obsRsPend); end
      total++; if (obsWrite !== 1'b0)  begin bad++; $display("FAIL rstmid_empty got=%b exp=0", obsWrite); end
      clearInputs();
      exp_q.delete();
   endtask

   task automatic test_random();
      bit priHold = 1'b0;
      bit secHold = 1'b0;
      int priPct;
      logic [36:0] e;
      clearInputs();
      exp_q.delete();
      for (int c = 0; c < 800; c++) begin
         priPct = ((c / 100) % 2 == 1) ? 95 : 50;
         rst = ($urandom_range(0, 199) == 0);
         if (!priHold) begin
            PriValid = ($urandom_range(0, 99) < priPct);
            PriAddr = 5'($urandom_range(0, 7)); PriData = $urandom;
         end
         if (!secHold) begin
            SecValid = ($urandom_range(0, 99) < 40);
            SecAddr = 5'($urandom_range(0, 7)); SecData = $urandom;
         end
         RsAddr = 5'($urandom_range(0, 7));
         RtAddr = 5'($urandom_range(0, 7));
         step();
         total++; if (obsReady !== expReady)         begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, obsReady, expReady); end
         total++; if (obsStall !== expStall)         begin bad++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, obsStall, expStall); end
         total++; if (obsRsPend !== expRsPend)       begin bad++; $display("FAIL rnd_rspend c=%0d got=%b exp=%b", c, obsRsPend, expRsPend); end
         total++; if (obsRtPend !== expRtPend)       begin bad++; $display("FAIL rnd_rtpend c=%0d got=%b exp=%b", c, obsRtPend, expRtPend); end
         total++; if (obsRsFwd !== expRsFwd)         begin bad++; $display("FAIL rnd_rsfwd c=%0d got=%b exp=%b", c, obsRsFwd, expRsFwd); end
         total++; if (obsRtFwd !== expRtFwd)         begin bad++; $display("FAIL rnd_rtfwd c=%0d got=%b exp=%b", c, obsRtFwd, expRtFwd); end
         total++; if (obsRsFwdData !== expRsFwdData) begin bad++; $display("FAIL rnd_rsfwddata c=%0d got=%h exp=%h", c, obsRsFwdData, expRsFwdData); end
         total++; if (obsRtFwdData !== expRtFwdData) begin bad++; $display("FAIL rnd_rtfwddata c=%0d got=%h exp=%h", c, obsRtFwdData, expRtFwdData); end
         total++; if (obsWrite !== expWrite)         begin bad++; $display("FAIL rnd_regwrite c=%0d got=%b exp=%b", c, obsWrite, expWrite); end
         if (expWrite && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({obsAddr, obsData} !== e) begin
               bad++; $display("FAIL rnd_wrdata c=%0d got=%h/%h exp=%h/%h", c, obsAddr, obsData, e[36:32], e[31:0]);
            end
         end
         priHold = PriValid && obsStall && !rst;
         secHold = SecValid && !obsReady && !rst;
      end
      rst = 1'b0;
      clearInputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b0;
      mWait = 0;
      mStall = 1'b0;
      clearInputs();
      @(negedge clk);
      test_reset();
      test_primary();
      test_sec_push();
      test_starve();
      test_fifo_full();
      test_zero_addr();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
